// File: rtl/detector_dead_time.sv
// rtl/detector_dead_time.sv - single-photon detector dead-time model with accepted/lost counters
// Optional macro: DETECTOR_PARALYZABLE_EN (a photon during the dead period restarts the dead period)
module detector_dead_time #(
    parameter int SYNC_STAGES = 2,
    parameter int PW_W        = 8,
    parameter int DT_W        = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             photon_efficiency,
    input  logic [PW_W-1:0]  pulse_width,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             gate,
    input  logic             cnt_clear,
    output logic             det_out,
    output logic             busy,
    output logic [CNT_W-1:0] accepted_cnt,
    output logic [CNT_W-1:0] lost_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        DEAD  = 2'b10
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   rise;
    logic [PW_W-1:0]        pw_cnt, pw_cnt_n;
    logic [DT_W-1:0]        dt_cnt, dt_cnt_n;
    logic [DT_W-1:0]        dt_reg, dt_reg_n;
    logic                   accept;
    logic                   lose;

    // Synchronizer chain followed by a registered rising-edge strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], photon_efficiency};
            sync_prev <= sync_q[SYNC_STAGES-1];
            rise      <= sync_q[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    // Next-state and counter loads; config is sampled only on acceptance
    always_comb begin
        state_n  = state;
        pw_cnt_n = pw_cnt;
        dt_cnt_n = dt_cnt;
        dt_reg_n = dt_reg;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n  = PULSE;
                    pw_cnt_n = (pulse_width == '0) ? '0 : pulse_width - 1'b1;
                    dt_reg_n = dead_time;
                end
            end
            PULSE: begin
                if (pw_cnt != '0) begin
                    pw_cnt_n = pw_cnt - 1'b1;
                end else if (dt_reg == '0) begin
                    state_n = IDLE;
                end else begin
                    state_n  = DEAD;
                    dt_cnt_n = dt_reg - 1'b1;
                end
            end
            DEAD: begin
`ifdef DETECTOR_PARALYZABLE_EN
                if (rise) begin
                    dt_cnt_n = dt_reg - 1'b1;
                end else if (dt_cnt != '0) begin
                    dt_cnt_n = dt_cnt - 1'b1;
                end else begin
                    state_n = IDLE;
                end
`else
                if (dt_cnt != '0) begin
                    dt_cnt_n = dt_cnt - 1'b1;
                end else begin
                    state_n = IDLE;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept = rise & (state == IDLE);
    assign lose   = rise & (state != IDLE);

    // State register with outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pw_cnt  <= '0;
            dt_cnt  <= '0;
            dt_reg  <= '0;
            det_out <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            pw_cnt  <= pw_cnt_n;
            dt_cnt  <= dt_cnt_n;
            dt_reg  <= dt_reg_n;
            det_out <= (state_n == PULSE);
            busy    <= (state_n != IDLE);
        end
    end

    // Gated, saturating event counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted_cnt <= '0;
            lost_cnt     <= '0;
        end else if (cnt_clear) begin
            accepted_cnt <= '0;
            lost_cnt     <= '0;
        end else begin
            if (gate && accept && (accepted_cnt != '1)) begin
                accepted_cnt <= accepted_cnt + 1'b1;
            end
            if (gate && lose && (lost_cnt != '1)) begin
                lost_cnt <= lost_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_detector_dead_time.sv
// tb/tb_detector_dead_time.sv - directed self-checking bench for detector_dead_time
module tb_detector_dead_time;

    localparam int SYNC_STAGES = 2;
    localparam int PW_W        = 8;
    localparam int DT_W        = 16;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             photon_efficiency = 1'b0;
    logic [PW_W-1:0]  pulse_width = '0;
    logic [DT_W-1:0]  dead_time = '0;
    logic             gate = 1'b1;
    logic             cnt_clear = 1'b0;
    logic             det_out;
    logic             busy;
    logic [CNT_W-1:0] accepted_cnt;
    logic [CNT_W-1:0] lost_cnt;

    int nchk = 0;
    int nerr = 0;

    detector_dead_time #(
        .SYNC_STAGES(SYNC_STAGES),
        .PW_W(PW_W),
        .DT_W(DT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .photon_efficiency(photon_efficiency),
        .pulse_width(pulse_width),
        .dead_time(dead_time),
        .gate(gate),
        .cnt_clear(cnt_clear),
        .det_out(det_out),
        .busy(busy),
        .accepted_cnt(accepted_cnt),
        .lost_cnt(lost_cnt)
    );

    always #5 clk = ~clk;

    // Pulse-shape monitor sampled on the falling edge
    int   det_pulses = 0;
    int   det_hi     = 0;
    int   det_run    = 0;
    int   det_w_last = 0;
    int   busy_run   = 0;
    int   busy_w_last = 0;
    logic det_prev   = 1'b0;

    always @(negedge clk) begin
        if (det_out) begin
            det_run <= det_run + 1;
            det_hi  <= det_hi + 1;
        end else if (det_run != 0) begin
            det_w_last <= det_run;
            det_run    <= 0;
        end
        if (det_out && !det_prev) det_pulses <= det_pulses + 1;
        det_prev <= det_out;
        if (busy) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            busy_w_last <= busy_run;
            busy_run    <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle-wide photon; next photon starts gap cycles after this one
    task automatic photon(input int gap);
        @(negedge clk);
        photon_efficiency = 1'b1;
        @(negedge clk);
        photon_efficiency = 1'b0;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic clear_counters();
        @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
    endtask

    int lat;
    int p0, h0;

    initial begin
        // Reset state
        idle(2);
        #1;
        check("rst_det_out", det_out, 0);
        check("rst_busy", busy, 0);
        check("rst_acc", accepted_cnt, 0);
        check("rst_lost", lost_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // 1: two well-separated photons, latency of the first pulse
        pulse_width = 8'd4;
        dead_time   = 16'd10;
        p0 = det_pulses;
        h0 = det_hi;
        @(negedge clk);
        photon_efficiency = 1'b1;
        lat = 0;
        while (!det_out && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                @(negedge clk);
                photon_efficiency = 1'b0;
            end
        end
        check("t1_latency", lat, SYNC_STAGES + 2);
        idle(17);
        photon(20);
        idle(10);
        check("t1_pulses", det_pulses - p0, 2);
        check("t1_high_cycles", det_hi - h0, 8);
        check("t1_width", det_w_last, 4);
        check("t1_busy_width", busy_w_last, 14);
        check("t1_acc", accepted_cnt, 2);
        check("t1_lost", lost_cnt, 0);

        // 2: second photon in DEAD is lost, photon at offset 15 is accepted
        clear_counters();
        p0 = det_pulses;
        photon(8);
        photon(7);
        photon(20);
        idle(5);
        check("t2_pulses", det_pulses - p0, 2);
        check("t2_acc", accepted_cnt, 2);
        check("t2_lost", lost_cnt, 1);

        // 2b: photon at offset 14 lands in DEAD's exit cycle and is lost
        clear_counters();
        p0 = det_pulses;
        photon(14);
        photon(30);
        check("t2b_pulses", det_pulses - p0, 1);
        check("t2b_acc", accepted_cnt, 1);
        check("t2b_lost", lost_cnt, 1);

        // 3: zero width and zero dead time, photons every 3 cycles
        pulse_width = 8'd0;
        dead_time   = 16'd0;
        clear_counters();
        p0 = det_pulses;
        h0 = det_hi;
        repeat (6) photon(3);
        idle(8);
        check("t3_pulses", det_pulses - p0, 6);
        check("t3_high_cycles", det_hi - h0, 6);
        check("t3_busy_width", busy_w_last, 1);
        check("t3_acc", accepted_cnt, 6);
        check("t3_lost", lost_cnt, 0);

        // 4: saturation, clear in the rise cycle, gate low
        pulse_width = 8'd1;
        clear_counters();
        repeat (20) photon(3);
        idle(8);
        check("t4_saturate", accepted_cnt, 15);
        check("t4_sat_lost", lost_cnt, 0);
        @(negedge clk);
        photon_efficiency = 1'b1;
        @(negedge clk);
        photon_efficiency = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
        check("t4_clear_wins", accepted_cnt, 0);
        idle(6);
        check("t4_after_clear", accepted_cnt, 0);
        gate = 1'b0;
        p0 = det_pulses;
        repeat (3) photon(3);
        idle(8);
        check("t4_gate0_pulses", det_pulses - p0, 3);
        check("t4_gate0_acc", accepted_cnt, 0);
        check("t4_gate0_lost", lost_cnt, 0);
        gate = 1'b1;

        // 5: reset during DEAD with the input held high through release
        pulse_width = 8'd4;
        dead_time   = 16'd10;
        photon(2);
        idle(8);
        check("t5_in_dead", busy, 1);
        photon_efficiency = 1'b1;
        rst = 1'b1;
        #1;
        check("t5_rst_det", det_out, 0);
        check("t5_rst_busy", busy, 0);
        idle(3);
        check("t5_rst_acc", accepted_cnt, 0);
        check("t5_rst_lost", lost_cnt, 0);
        p0 = det_pulses;
        rst = 1'b0;
        idle(30);
        photon_efficiency = 1'b0;
        idle(20);
        check("t5_pulses", det_pulses - p0, 1);
        check("t5_acc", accepted_cnt, 1);
        check("t5_lost", lost_cnt, 0);

        // 6: five photons every 8 cycles with pulse 2, dead 10
        pulse_width = 8'd2;
        dead_time   = 16'd10;
        clear_counters();
        p0 = det_pulses;
        repeat (5) photon(8);
        idle(40);
`ifdef DETECTOR_PARALYZABLE_EN
        check("t6_pulses", det_pulses - p0, 1);
        check("t6_acc", accepted_cnt, 1);
        check("t6_lost", lost_cnt, 4);
        check("t6_busy_width", busy_w_last, 42);
`else
        check("t6_pulses", det_pulses - p0, 3);
        check("t6_acc", accepted_cnt, 3);
        check("t6_lost", lost_cnt, 2);
        check("t6_busy_width", busy_w_last, 12);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/detector_dead_time.md
Name: detector_dead_time

Overview:
Downstream stage of the efficiency-thinning block. It consumes the asynchronous thinned photon pulse train `photon_efficiency` and models single-photon detector dead time. Each accepted photon produces one fixed-width, clock-aligned detector pulse. Photons arriving while the detector is busy are discarded and counted as lost. Accepted and lost totals are counted within a gate window for efficiency measurement.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer (minimum 2).
- PW_W, 8, width of the `pulse_width` input.
- DT_W, 16, width of the `dead_time` input.
- CNT_W, 16, width of the accepted and lost counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- photon_efficiency  input  1  asynchronous photon pulse from the thinning stage.
- pulse_width  input  PW_W  output pulse length in clk cycles; 0 is treated as 1.
- dead_time  input  DT_W  dead period in clk cycles after the pulse ends; 0 means no dead period.
- gate  input  1  counting window enable.
- cnt_clear  input  1  synchronous clear of both counters.
- det_out  output  1  detector output pulse, registered.
- busy  output  1  high when the FSM is in PULSE or DEAD.
- accepted_cnt  output  CNT_W  count of accepted photons, saturating.
- lost_cnt  output  CNT_W  count of photons lost to dead time, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - det_out=0, busy=0, accepted_cnt=0, lost_cnt=0.
  - All synchronizer and edge registers are cleared to 0.
  - An input already high at reset release therefore yields one rising edge.
- Input path:
  - SYNC_STAGES-FF synchronizer, then a registered rising-edge detector producing a one-cycle strobe `rise`.
  - Guaranteed detection requires the input to be high ≥1 clk period and low ≥1 clk period between pulses. Narrower pulses may be missed.
- FSM states: IDLE, PULSE, DEAD.
  - IDLE: `rise` → PULSE. Load pw_cnt = max(pulse_width,1)-1 and latch dead_time into dt_reg. Increment accepted.
  - PULSE: det_out=1.
    - pw_cnt≠0: decrement.
    - pw_cnt==0 and dt_reg==0: → IDLE.
    - pw_cnt==0 and dt_reg≠0: → DEAD, load dt_cnt = dt_reg-1.
  - DEAD: det_out=0.
    - dt_cnt≠0: decrement.
    - dt_cnt==0: → IDLE.
  - Any `rise` while in PULSE or DEAD increments lost, including the exit cycle of either state.
- Timing:
  - `rise` is in cycle n.
  - det_out is high in cycles n+1 … n+P, where P = max(pulse_width,1).
  - busy is high in cycles n+1 … n+P+D, where D = dead_time.
  - The earliest next accepted `rise` is cycle n+P+D+1.
- Configuration sampling: pulse_width and dead_time are sampled only on acceptance. Changes mid-event take effect on the next accepted photon.
- Counters:
  - Increment only when gate=1 in the `rise` cycle.
  - Saturate at all-ones; no wrap.
  - cnt_clear has priority over increment in the same cycle. Counters read 0 in the cycle after a clear.
- det_out and busy are unaffected by gate and cnt_clear.

Optional Feature:
- Macro: DETECTOR_PARALYZABLE_EN.
- Defined (paralyzable dead time): a `rise` in DEAD reloads dt_cnt = dt_reg-1 and is counted as lost. A `rise` in PULSE is lost and does not extend the pulse.
- Undefined (non-paralyzable): a `rise` in DEAD is counted as lost and does not alter dt_cnt.

Test Plan:
1. pulse_width=4, dead_time=10, gate=1, two photons 20 clk apart → two det_out pulses of exactly 4 cycles each, accepted_cnt=2, lost_cnt=0; first det_out rises SYNC_STAGES+2 cycles after the input edge.
2. pulse_width=4, dead_time=10, photons 8 clk apart (second lands in DEAD), then a third 15 clk after the first → one det_out pulse for the first, no pulse for the second, one pulse for the third; accepted_cnt=2, lost_cnt=1. A photon arriving at offset 4+10+1 from `rise` is accepted.
3. pulse_width=0, dead_time=0, photons every 3 clk → 1-cycle det_out per photon, busy high 1 cycle, all accepted.
4. CNT_W=4, 20 accepted photons with gate=1 → accepted_cnt holds 15. Assert cnt_clear in the same cycle as a `rise` → counter=0 the next cycle. Photons with gate=0 → det_out pulses but counters unchanged.
5. Assert rst during DEAD, and hold photon_efficiency high through reset release → all outputs 0 during reset; after release exactly one accepted event is generated.
6. With DETECTOR_PARALYZABLE_EN defined, dead_time=10, pulse_width=2, photons every 8 clk for 5 photons → only the first accepted, lost_cnt=4, busy stays high until 10 cycles after the last photon's `rise` ends DEAD. Without the macro, the same stimulus → photons 1, 3 and 5 accepted (8 cycles apart, busy window 12 cycles), lost_cnt=2.
